// File: rtl/boron_stream_ctrl.sv
// -----------------------------------------------------------------------------
// boron_stream_ctrl
//
// Upstream feeder for the BORON block cipher core (64-bit block, 80-bit key).
// Plaintext blocks are queued in a small FIFO. Each block is handed to the
// core with a single start pulse. The controller then waits for the core to
// signal completion and presents the result on a valid/ready output port.
// Only one block is in flight at a time. A per-block timeout abandons a block
// whose core never completes, and sets a sticky error flag. A 16-bit counter
// counts results accepted downstream.
//
// Ports
//   clk             in   1   clock, all state on rising edge
//   reset           in   1   asynchronous, active-low reset
//   in_valid        in   1   upstream block valid
//   in_ready        out  1   FIFO can accept (not full)
//   in_data         in   64  plaintext block
//   key_load        in   1   load key_in into the key register (IDLE only)
//   key_in          in   80  new key value
//   core_start      out  1   one-cycle start pulse to the core
//   core_state_in   out  64  block under processing, held from ISSUE to WAIT
//   core_key        out  80  key register driven to the core
//   core_done       in   1   core completion level, taken only in WAIT
//   core_state_out  in   64  core result, sampled when core_done is taken
//   out_valid       out  1   result available
//   out_ready       in   1   downstream accepts result
//   out_data        out  64  result block
//   timeout_err     out  1   sticky timeout flag, cleared only by reset
//   blk_count       out  16  results accepted downstream (wraps)
// -----------------------------------------------------------------------------
module boron_stream_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        key_load,
    input  logic [79:0] key_in,
    output logic        core_start,
    output logic [63:0] core_state_in,
    output logic [79:0] core_key,
    input  logic        core_done,
    input  logic [63:0] core_state_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        timeout_err,
    output logic [15:0] blk_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [63:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic [15:0]        r_timer;
    logic [79:0]        r_core_key;
    logic [63:0]        r_core_state_in;
    logic [63:0]        r_out_data;
    logic               r_timeout_err;
    logic [15:0]        r_blk_count;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_timer_exp;
    logic               w_accept;

    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push      = in_valid && !w_full;
    // A key load in IDLE wins over issuing, so the pop waits one cycle.
    assign w_pop       = (r_state == S_IDLE) && !key_load && !w_empty;
    assign w_timer_exp = (r_timer == 16'(TIMEOUT - 1));
    assign w_accept    = (r_state == S_HOLD) && out_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_pop) w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT: begin
                if (core_done)        w_next_state = S_HOLD;
                else if (w_timer_exp) w_next_state = S_IDLE;
            end
            S_HOLD:  if (out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Decoded straight from the state register so that an asynchronous
    // reset drops core_start and out_valid immediately.
    always_comb begin
        core_start = 1'b0;
        out_valid  = 1'b0;
        in_ready   = !w_full;
        case (r_state)
            S_ISSUE: core_start = 1'b1;
            S_HOLD:  out_valid  = 1'b1;
            default: ;
        endcase
    end

    // ---------------- FIFO storage (no reset needed on data) ----------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // ---------------- FIFO pointers and occupancy ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_core_key      <= '0;
            r_core_state_in <= '0;
            r_out_data      <= '0;
            r_timer         <= '0;
            r_timeout_err   <= 1'b0;
            r_blk_count     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (key_load) begin
                        r_core_key <= key_in;
                    end else if (!w_empty) begin
                        r_core_state_in <= r_mem[r_rd_ptr];
                    end
                end
                S_ISSUE: r_timer <= '0;
                S_WAIT: begin
                    if (core_done) begin
                        r_out_data <= core_state_out;
                    end else if (w_timer_exp) begin
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                default: ;
            endcase
            if (w_accept) begin
                r_blk_count <= r_blk_count + 16'd1;
            end
        end
    end

    assign core_key      = r_core_key;
    assign core_state_in = r_core_state_in;
    assign out_data      = r_out_data;
    assign timeout_err   = r_timeout_err;
    assign blk_count     = r_blk_count;

endmodule
